dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Multi-cycle data-memory target serving the pipeline's Memory-stage load/store requests.
- Captures address, write data and access size when a request arrives, and stalls the pipeline through the hazard unit for a fixed latency.
- Then performs the byte/half/word write, or the sign/zero-extended read, and returns load data with a one-cycle done pulse.
- Sits between the M-stage register outputs and the W-stage register's ReadDataM input.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, minimum 4.
- LATENCY, 2, BUSY-state cycles before the access commits; minimum 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- MemReqM  input  1  M-stage instruction is a load or store.
- MemWriteM  input  1  1 = store, 0 = load; sampled with MemReqM.
- AddrM  input  32  byte address (ALUResultM).
- WriteDataM  input  32  store data, right-justified.
- Funct3M  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- ReadDataM  output  32  extended load data, held until the next load completes.
- MemStallM  output  1  stall request to the hazard unit.
- MemDoneM  output  1  one-cycle pulse when the access has completed.

Behaviour:
- Reset: state IDLE; ReadDataM = 0; MemDoneM = 0; MemStallM = 0 (when MemReqM = 0); counter = 0. Memory array is not cleared.
- Reset asserted mid-operation: abort immediately. A store not yet committed is never written.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If MemReqM = 1: latch AddrM, WriteDataM, MemWriteM and Funct3M; load counter with LATENCY-1; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If counter == 0: commit the access and go to RESP.
  - Otherwise decrement the counter.
- RESP:
  - MemDoneM = 1.
  - Always returns to IDLE.
  - MemReqM is ignored in this state; the next request is seen in IDLE on the following cycle.
- MemStallM = (IDLE & MemReqM) | BUSY. This is combinational from MemReqM in IDLE and is 0 in RESP.
- Latency: for a request first seen in cycle 0, MemStallM is high in cycles 0 through LATENCY; MemDoneM pulses in cycle LATENCY+1.
- Word index = latched address bits [log2(DEPTH_WORDS)+1 : 2]. Higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Stores, using the latched address's low two bits (off):
  - sb writes byte lane off.
  - sh writes half lane addr[1].
  - sw writes all four lanes.
  - Other lanes are unchanged.
- Loads:
  - lb/lbu select byte lane off; lh/lhu select half lane addr[1]; lw selects the whole word.
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - ReadDataM updates at the commit edge, so it is valid in the RESP cycle.
- Stores leave ReadDataM unchanged.
- Undefined Funct3M values (011, 110, 111): no write; a load returns 0.
- Without the optional feature, misaligned offsets are truncated: sw/lw ignore addr[1:0]; sh/lh ignore addr[0].

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined:
  - Adds output MisalignM (1 bit, reset 0).
  - A request is misaligned if it is a halfword with addr[0] = 1, or a word with addr[1:0] != 0.
  - A misaligned request still runs the full IDLE/BUSY/RESP timing.
  - Its write is suppressed; a load returns ReadDataM = 0.
  - MisalignM = 1 in the RESP cycle only.
- Undefined: port absent; truncation rules apply.

Test Plan (LATENCY=2, DEPTH_WORDS=1024):
- Store then load: sw 0xDEADBEEF to 0x100, then lw from 0x100 → MemStallM high for 3 cycles per access; MemDoneM pulses in cycle 3; ReadDataM = 0xDEADBEEF.
- Byte/half extension: sw 0x80FF7F01 to 0x40, then:
  - lb 0x43 → 0xFFFFFF80;
  - lbu 0x41 → 0x0000007F;
  - lh 0x40 → 0x00007F01;
  - lhu 0x42 → 0x000080FF.
- Partial store: sw 0x00000000 to 0x20; sb 0xAB to 0x22; sh 0x1234 to 0x20; lw 0x20 → 0x00AB1234.
- Address wrap: sw 0x11111111 to 0x1000, then lw from 0x0 → 0x11111111.
- Reset mid-op: sw 0x55 to 0x8 (word at 0x8 previously 0x0); assert rst in the first BUSY cycle → state IDLE, MemStallM = 0, ReadDataM = 0; a later lw from 0x8 returns 0x0.
- Back-to-back: MemReqM held high across RESP → second access starts in the cycle after RESP; MemStallM low exactly one cycle between accesses. With DMEM_MISALIGN_CHECK_EN, lw from 0x102 → MisalignM = 1 and ReadDataM = 0 in the RESP cycle.

Source files
------------

// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
// Bundles the Memory-stage request/response signals between the pipeline
// (master) and the data-memory responder (slave).
//   MemReqM     master->slave  load/store request
//   MemWriteM   master->slave  1 = store, 0 = load
//   AddrM       master->slave  byte address
//   WriteDataM  master->slave  right-justified store data
//   Funct3M     master->slave  access size / sign
//   ReadDataM   slave->master  extended load data
//   MemStallM   slave->master  stall request to the hazard unit
//   MemDoneM    slave->master  one-cycle completion pulse
//   MisalignM   slave->master  misaligned-access flag (only when
//                              DMEM_MISALIGN_CHECK_EN is defined)
// ---------------------------------------------------------------------------
interface dmem_responder_if;
  logic        MemReqM;
  logic        MemWriteM;
  logic [31:0] AddrM;
  logic [31:0] WriteDataM;
  logic [2:0]  Funct3M;
  logic [31:0] ReadDataM;
  logic        MemStallM;
  logic        MemDoneM;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic        MisalignM;

  modport master (
    output MemReqM, MemWriteM, AddrM, WriteDataM, Funct3M,
    input  ReadDataM, MemStallM, MemDoneM, MisalignM
  );

  modport slave (
    input  MemReqM, MemWriteM, AddrM, WriteDataM, Funct3M,
    output ReadDataM, MemStallM, MemDoneM, MisalignM
  );
`else
  modport master (
    output MemReqM, MemWriteM, AddrM, WriteDataM, Funct3M,
    input  ReadDataM, MemStallM, MemDoneM
  );

  modport slave (
    input  MemReqM, MemWriteM, AddrM, WriteDataM, Funct3M,
    output ReadDataM, MemStallM, MemDoneM
  );
`endif
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Multi-cycle data-memory target for the Memory stage. A request seen in
// IDLE is latched, the pipeline is stalled for LATENCY BUSY cycles, then the
// byte/half/word store or the sign/zero-extended load is committed and
// MemDoneM pulses for one cycle in RESP.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   LATENCY      BUSY cycles before the access commits (>= 1)
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   bus          dmem_responder_if.slave (request in, ReadDataM/MemStallM/
//                MemDoneM out)
// Optional feature macro: DMEM_MISALIGN_CHECK_EN
//   Adds bus.MisalignM; misaligned halfword/word accesses keep full timing,
//   suppress their write, return 0 on load and flag MisalignM in RESP.
//   Without it, misaligned offsets are truncated.
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // Counter only needs to hold LATENCY-1.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [IDX_W+1:0]   addr_r;
  logic [31:0]        wdata_r;
  logic               we_r;
  logic [2:0]         f3_r;
  logic [31:0]        read_data_r;
  logic               done_r;
  logic               stall_s;
  logic               commit_s;
  logic               misal_s;
  logic [3:0]         wr_lanes_s;
  logic [31:0]        wdata_aligned_s;
  logic [IDX_W-1:0]   word_idx_s;
  logic [31:0]        rd_word_s;
  logic [31:0]        mem_r [DEPTH_WORDS];

  // Extend the selected byte/half of a memory word; undefined sizes give 0.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b010:  load_extend = word;
      3'b100:  load_extend = {24'd0, b};
      3'b101:  load_extend = {16'd0, h};
      default: load_extend = 32'd0;
    endcase
  endfunction

  // Byte lanes written by a store; undefined sizes write nothing.
  function automatic logic [3:0] store_lanes(input logic [1:0] off,
                                             input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: store_lanes = 4'b0001 << off;
      3'b001, 3'b101: store_lanes = off[1] ? 4'b1100 : 4'b0011;
      3'b010:         store_lanes = 4'b1111;
      default:        store_lanes = 4'b0000;
    endcase
  endfunction

  // Replicate right-justified store data across the lanes it may land in.
  function automatic logic [31:0] store_align(input logic [31:0] wdata,
                                              input logic [2:0]  f3);
    case (f3[1:0])
      2'b00:   store_align = {4{wdata[7:0]}};
      2'b01:   store_align = {2{wdata[15:0]}};
      default: store_align = wdata;
    endcase
  endfunction

`ifdef DMEM_MISALIGN_CHECK_EN
  logic misalign_r;

  // Halfword with addr[0] set, or word with any low address bit set.
  function automatic logic is_misaligned(input logic [1:0] off,
                                         input logic [2:0] f3);
    case (f3)
      3'b001, 3'b101: is_misaligned = off[0];
      3'b010:         is_misaligned = (off != 2'b00);
      default:        is_misaligned = 1'b0;
    endcase
  endfunction

  assign misal_s       = is_misaligned(addr_r[1:0], f3_r);
  assign bus.MisalignM = misalign_r;
`else
  assign misal_s = 1'b0;
`endif

  assign word_idx_s      = addr_r[IDX_W+1:2];
  assign rd_word_s       = mem_r[word_idx_s];
  assign wdata_aligned_s = store_align(wdata_r, f3_r);
  assign commit_s        = (state_r == ST_BUSY) && (cnt_r == CNT_ZERO);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.MemReqM) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output logic: stall is combinational from MemReqM while idle.
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.MemReqM) begin
          stall_s = 1'b1;
        end else begin
          stall_s = 1'b0;
        end
      end
      ST_BUSY: stall_s = 1'b1;
      ST_RESP: stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
  end

  // Request capture and latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= CNT_ZERO;
      addr_r  <= {(IDX_W+2){1'b0}};
      wdata_r <= 32'd0;
      we_r    <= 1'b0;
      f3_r    <= 3'b000;
    end else if ((state_r == ST_IDLE) && bus.MemReqM) begin
      cnt_r   <= CNT_LOAD;
      addr_r  <= bus.AddrM[IDX_W+1:0];
      wdata_r <= bus.WriteDataM;
      we_r    <= bus.MemWriteM;
      f3_r    <= bus.Funct3M;
    end else if ((state_r == ST_BUSY) && (cnt_r != CNT_ZERO)) begin
      cnt_r   <= cnt_r - CNT_ONE;
    end else begin
      cnt_r   <= cnt_r;
    end
  end

  // Store lane enables; reset in the commit cycle cancels the write.
  always_comb begin
    wr_lanes_s = 4'b0000;
    if (commit_s && we_r && !misal_s && !rst) begin
      wr_lanes_s = store_lanes(addr_r[1:0], f3_r);
    end else begin
      wr_lanes_s = 4'b0000;
    end
  end

  // Memory array byte-lane writes (array is intentionally not reset).
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_lanes_s[i]) begin
        mem_r[word_idx_s][i*8 +: 8] <= wdata_aligned_s[i*8 +: 8];
      end
    end
  end

  // Registered response outputs, updated at the commit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data_r <= 32'd0;
      done_r      <= 1'b0;
    end else begin
      done_r <= commit_s;
      if (commit_s && !we_r) begin
        read_data_r <= misal_s ? 32'd0 : load_extend(rd_word_s, addr_r[1:0], f3_r);
      end else begin
        read_data_r <= read_data_r;
      end
    end
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  // Misalign flag, high only in the RESP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= commit_s && misal_s;
    end
  end
`endif

  assign bus.ReadDataM = read_data_r;
  assign bus.MemStallM = stall_s;
  assign bus.MemDoneM  = done_r;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Directed self-checking bench for dmem_responder (LATENCY=2,
// DEPTH_WORDS=1024). Inputs change on the falling edge; outputs are sampled
// 1 time unit after the falling edge. Cycle 0 is the cycle in which a
// request is first presented.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Results of the most recent access() call.
  logic [31:0] rd_o;
  int          stall_o;
  int          done_o;
  logic        mis_o;

  // Present one request, hold it until MemDoneM, then drop it.
  task automatic access(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3);
    @(negedge clk);
    bus.MemReqM    = 1'b1;
    bus.MemWriteM  = we;
    bus.AddrM      = addr;
    bus.WriteDataM = wdata;
    bus.Funct3M    = f3;
    done_o  = -1;
    stall_o = 0;
    rd_o    = 32'd0;
    mis_o   = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.MemStallM === 1'b1) stall_o++;
      if (bus.MemDoneM === 1'b1) begin
        done_o = c;
        rd_o   = bus.ReadDataM;
`ifdef DMEM_MISALIGN_CHECK_EN
        mis_o  = bus.MisalignM;
`endif
        bus.MemReqM = 1'b0;
        break;
      end
      @(negedge clk);
    end
    bus.MemReqM = 1'b0;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.MemReqM    = 1'b0;
    bus.MemWriteM  = 1'b0;
    bus.AddrM      = 32'd0;
    bus.WriteDataM = 32'd0;
    bus.Funct3M    = 3'b000;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.MemStallM !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b expected 0", bus.MemStallM);
    end
    checks++;
    if (bus.MemDoneM !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b expected 0", bus.MemDoneM);
    end
    checks++;
    if (bus.ReadDataM !== 32'd0) begin
      errors++; $display("FAIL reset_rdata: got %h expected 00000000", bus.ReadDataM);
    end
`ifdef DMEM_MISALIGN_CHECK_EN
    checks++;
    if (bus.MisalignM !== 1'b0) begin
      errors++; $display("FAIL reset_misalign: got %b expected 0", bus.MisalignM);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    access(1'b1, 32'h100, 32'hDEADBEEF, 3'b010);
    checks++;
    if (stall_o !== 3 || done_o !== 3) begin
      errors++; $display("FAIL sw_timing: got stall=%0d done_cycle=%0d expected 3/3", stall_o, done_o);
    end
    checks++;
    if (rd_o !== 32'd0) begin
      errors++; $display("FAIL sw_keeps_rdata: got %h expected 00000000", rd_o);
    end
    access(1'b0, 32'h100, 32'd0, 3'b010);
    checks++;
    if (stall_o !== 3 || done_o !== 3) begin
      errors++; $display("FAIL lw_timing: got stall=%0d done_cycle=%0d expected 3/3", stall_o, done_o);
    end
    checks++;
    if (rd_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lw_data: got %h expected deadbeef", rd_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.MemDoneM !== 1'b0 || bus.MemStallM !== 1'b0) begin
      errors++; $display("FAIL done_pulse_width: got done=%b stall=%b expected 0/0", bus.MemDoneM, bus.MemStallM);
    end
    checks++;
    if (bus.ReadDataM !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rdata_hold: got %h expected deadbeef", bus.ReadDataM);
    end
  endtask

  task automatic test_extension();
    logic [31:0] addr_t [6];
    logic [2:0]  f3_t   [6];
    logic [31:0] exp_t  [6];
    addr_t = '{32'h43, 32'h41, 32'h40, 32'h42, 32'h42, 32'h40};
    f3_t   = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b011};
    exp_t  = '{32'hFFFFFF80, 32'h0000007F, 32'h00007F01, 32'h000080FF,
               32'hFFFF80FF, 32'h00000000};
    access(1'b1, 32'h40, 32'h80FF7F01, 3'b010);
    for (int i = 0; i < 6; i++) begin
      access(1'b0, addr_t[i], 32'd0, f3_t[i]);
      checks++;
      if (rd_o !== exp_t[i] || done_o !== 3) begin
        errors++;
        $display("FAIL ext_load[%0d]: got %h (done_cycle=%0d) expected %h", i, rd_o, done_o, exp_t[i]);
      end
    end
    // Undefined store size must not touch memory.
    access(1'b1, 32'h40, 32'hFFFFFFFF, 3'b111);
    access(1'b0, 32'h40, 32'd0, 3'b010);
    checks++;
    if (rd_o !== 32'h80FF7F01) begin
      errors++; $display("FAIL undef_store: got %h expected 80ff7f01", rd_o);
    end
  endtask

  task automatic test_partial_store();
    access(1'b1, 32'h20, 32'h00000000, 3'b010);
    access(1'b1, 32'h22, 32'h000000AB, 3'b000);
    access(1'b1, 32'h20, 32'h00001234, 3'b001);
    access(1'b0, 32'h20, 32'd0, 3'b010);
    checks++;
    if (rd_o !== 32'h00AB1234) begin
      errors++; $display("FAIL partial_store: got %h expected 00ab1234", rd_o);
    end
  endtask

  task automatic test_wrap();
    access(1'b1, 32'h1000, 32'h11111111, 3'b010);
    access(1'b0, 32'h0, 32'd0, 3'b010);
    checks++;
    if (rd_o !== 32'h11111111) begin
      errors++; $display("FAIL addr_wrap: got %h expected 11111111", rd_o);
    end
  endtask

  task automatic test_reset_midop();
    bit done_seen;
    access(1'b1, 32'h8, 32'h0, 3'b010);
    @(negedge clk);
    bus.MemReqM    = 1'b1;
    bus.MemWriteM  = 1'b1;
    bus.AddrM      = 32'h8;
    bus.WriteDataM = 32'h55;
    bus.Funct3M    = 3'b010;
    @(negedge clk);
    #1;
    checks++;
    if (bus.MemStallM !== 1'b1) begin
      errors++; $display("FAIL midop_busy_stall: got %b expected 1", bus.MemStallM);
    end
    rst         = 1'b1;
    bus.MemReqM = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.MemStallM !== 1'b0 || bus.MemDoneM !== 1'b0) begin
      errors++; $display("FAIL midop_abort: got stall=%b done=%b expected 0/0", bus.MemStallM, bus.MemDoneM);
    end
    checks++;
    if (bus.ReadDataM !== 32'd0) begin
      errors++; $display("FAIL midop_rdata: got %h expected 00000000", bus.ReadDataM);
    end
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (bus.MemDoneM === 1'b1) done_seen = 1'b1;
    end
    checks++;
    if (done_seen !== 1'b0) begin
      errors++; $display("FAIL midop_no_done: got done pulse expected none");
    end
    access(1'b0, 32'h8, 32'd0, 3'b010);
    checks++;
    if (rd_o !== 32'd0 || done_o !== 3) begin
      errors++; $display("FAIL midop_no_write: got %h (done_cycle=%0d) expected 00000000/3", rd_o, done_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  stall_pat;
    logic [7:0]  done_pat;
    logic [31:0] rd2;
    stall_pat = 8'd0;
    done_pat  = 8'd0;
    rd2       = 32'd0;
    @(negedge clk);
    bus.MemReqM    = 1'b1;
    bus.MemWriteM  = 1'b1;
    bus.AddrM      = 32'h200;
    bus.WriteDataM = 32'hCAFEF00D;
    bus.Funct3M    = 3'b010;
    for (int c = 0; c < 8; c++) begin
      #1;
      stall_pat[c] = bus.MemStallM;
      done_pat[c]  = bus.MemDoneM;
      if (c == 3) begin
        bus.MemWriteM  = 1'b0;
        bus.WriteDataM = 32'd0;
      end
      if (c == 7) begin
        rd2         = bus.ReadDataM;
        bus.MemReqM = 1'b0;
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (stall_pat !== 8'b0111_0111) begin
      errors++; $display("FAIL b2b_stall: got %b expected 01110111", stall_pat);
    end
    checks++;
    if (done_pat !== 8'b1000_1000) begin
      errors++; $display("FAIL b2b_done: got %b expected 10001000", done_pat);
    end
    checks++;
    if (rd2 !== 32'hCAFEF00D) begin
      errors++; $display("FAIL b2b_data: got %h expected cafef00d", rd2);
    end
    checks++;
    if (bus.MemStallM !== 1'b0) begin
      errors++; $display("FAIL b2b_idle_after: got %b expected 0", bus.MemStallM);
    end
  endtask

  task automatic test_misalign();
    access(1'b1, 32'h300, 32'h00000000, 3'b010);
    access(1'b1, 32'h303, 32'hA5A5A5A5, 3'b010);
`ifdef DMEM_MISALIGN_CHECK_EN
    checks++;
    if (mis_o !== 1'b1 || done_o !== 3) begin
      errors++; $display("FAIL mis_store_flag: got %b (done_cycle=%0d) expected 1/3", mis_o, done_o);
    end
    access(1'b0, 32'h300, 32'd0, 3'b010);
    checks++;
    if (rd_o !== 32'd0 || mis_o !== 1'b0) begin
      errors++; $display("FAIL mis_store_suppressed: got %h mis=%b expected 00000000/0", rd_o, mis_o);
    end
    access(1'b0, 32'h102, 32'd0, 3'b010);
    checks++;
    if (rd_o !== 32'd0 || mis_o !== 1'b1 || done_o !== 3) begin
      errors++; $display("FAIL mis_load: got %h mis=%b done_cycle=%0d expected 00000000/1/3", rd_o, mis_o, done_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.MisalignM !== 1'b0) begin
      errors++; $display("FAIL mis_pulse_width: got %b expected 0", bus.MisalignM);
    end
`else
    access(1'b0, 32'h300, 32'd0, 3'b010);
    checks++;
    if (rd_o !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL trunc_store: got %h expected a5a5a5a5", rd_o);
    end
    access(1'b0, 32'h102, 32'd0, 3'b010);
    checks++;
    if (rd_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL trunc_lw: got %h expected deadbeef", rd_o);
    end
    access(1'b0, 32'h43, 32'd0, 3'b001);
    checks++;
    if (rd_o !== 32'hFFFF80FF) begin
      errors++; $display("FAIL trunc_lh: got %h expected ffff80ff", rd_o);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store_load();
    test_extension();
    test_partial_store();
    test_wrap();
    test_reset_midop();
    test_back_to_back();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
